// File: rtl/if_fetch_unit.sv
// SimpleRisc instruction fetch stage feeding the IF/OF latch.
// Define FETCH_PERF_CNT_EN to add fetch/flush performance counters.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_pc_i,
    input  logic        stall_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        kill;

    logic        accept;
    logic        loadable;
    logic [31:0] redirect_pc;
    logic        unused_pc_bits;

    assign accept         = valid_o & ~stall_i;
    assign loadable       = ~valid_o | accept;
    assign redirect_pc    = {branch_pc_i[31:2], 2'b00};
    assign unused_pc_bits = ^branch_pc_i[1:0];

    // Request is held off while reset is asserted, then issues immediately.
    assign imem_req_o  = reset & (state == S_REQ);
    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_REQ;
            fetch_pc      <= PC_RESET;
            inflight_pc   <= '0;
            hold_instr    <= '0;
            hold_pc       <= '0;
            kill          <= 1'b0;
            instruction_o <= '0;
            pc_o          <= '0;
            valid_o       <= 1'b0;
        end else if (branch_taken_i) begin
            fetch_pc <= redirect_pc;
            valid_o  <= 1'b0;
            unique case (state)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state <= S_WAIT;
                        kill  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state <= S_REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            if (accept) begin
                valid_o <= 1'b0;
            end
            unique case (state)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        inflight_pc <= fetch_pc;
                        fetch_pc    <= fetch_pc + STEP;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (loadable) begin
                            instruction_o <= imem_rdata_i;
                            pc_o          <= inflight_pc;
                            valid_o       <= 1'b1;
                            state         <= S_REQ;
                        end else begin
                            hold_instr <= imem_rdata_i;
                            hold_pc    <= inflight_pc;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (loadable) begin
                        instruction_o <= hold_instr;
                        pc_o          <= hold_pc;
                        valid_o       <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (accept) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (branch_taken_i) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the SimpleRisc pipeline and the producer side of the IF/OF pipeline register. It owns the PC and issues requests to instruction memory. It delivers each fetched instruction with its PC on a valid/stall interface that feeds the IF/OF latch. It also handles branch redirects from later stages, and memory latency and downstream stalls are absorbed by a one-entry hold buffer.

Parameters:
PC_RESET, 32'h00000000, PC of the first fetch after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  active-low asynchronous reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address, bits [1:0] always 0
imem_gnt_i  input  1  memory accepted request this cycle
imem_rvalid_i  input  1  read data valid; exactly one per granted request, at least 1 cycle after grant
imem_rdata_i  input  32  instruction word
branch_taken_i  input  1  redirect request from EX/branch unit
branch_pc_i  input  32  redirect target
stall_i  input  1  IF/OF latch cannot accept this cycle
instruction_o  output  32  instruction to IF/OF latch
pc_o  output  32  PC of instruction_o
valid_o  output  1  instruction_o/pc_o valid

Behaviour:
- Reset (reset=0, async):
  - valid_o=0, instruction_o=0, pc_o=0, imem_req_o=0.
  - fetch_pc=PC_RESET, hold buffer empty, kill=0, state=REQ.
  - First request is asserted in the first cycle after reset deasserts.
- accept = valid_o & ~stall_i. Output register is loadable when ~valid_o | accept.
- While valid_o=1 and stall_i=1, instruction_o/pc_o/valid_o hold their values.
- FSM states:
  - REQ: imem_req_o=1, imem_addr_o=fetch_pc. On imem_gnt_i: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^32, so FFFFFFFC wraps to 0), go to WAIT.
  - WAIT: imem_req_o=0. On imem_rvalid_i:
    - kill=1: drop the data, clear kill, go to REQ.
    - Else, output loadable: load {imem_rdata_i, inflight_pc}, valid_o=1, go to REQ.
    - Else: store it in the hold buffer and go to HOLD.
  - HOLD: imem_req_o=0. When the output is loadable, move the hold buffer to the output, set valid_o=1, and go to REQ.
- If accept occurs and nothing new is loaded, valid_o<=0 next cycle.
- Redirect (branch_taken_i=1) has top priority over all same-cycle events:
  - fetch_pc<=branch_pc_i with bits [1:0] forced to 0.
  - valid_o<=0 (flush) and hold buffer discarded.
  - From REQ without grant: stay in REQ at the new PC next cycle.
  - From REQ with imem_gnt_i the same cycle: go to WAIT with kill=1.
  - From WAIT with no rvalid: kill<=1, stay in WAIT. With rvalid the same cycle: drop the data and go to REQ.
  - From HOLD: go to REQ.
- At most one outstanding memory request. Latency: with a grant in the same cycle and rvalid 1 cycle later, valid_o rises 2 cycles after imem_req_o first asserts. Throughput is one instruction per 2 cycles.
- Reset asserted mid-transaction clears all state. A late rvalid arriving in REQ state after reset is ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports fetch_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on every accept.
  - flush_cnt_o increments on every cycle with branch_taken_i=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory grants immediately with rvalid 1 cycle later, rdata=A5A5A5A5 then DEADBEEF, stall_i=0 -> imem_addr_o sequence 0,4,8. Output sequence {A5A5A5A5, pc 0} then {DEADBEEF, pc 4}, each valid_o=1 for one cycle.
- stall_i=1 for 5 cycles while valid_o=1 -> outputs frozen. Next response goes to the hold buffer and no new imem_req_o is issued. After stall_i drops, the held instruction appears with pc=previous+4.
- branch_taken_i=1 with branch_pc_i=0000010E during WAIT -> the pending response is dropped and valid_o stays 0. Next request address is 0000010C and the output pc is 0000010C.
- branch_taken_i and imem_gnt_i in the same REQ cycle -> the granted response is discarded and the next fetch is at the branch target.
- Redirect to FFFFFFFC -> pc_o=FFFFFFFC, then next fetch address 00000000.
- reset pulsed low mid-WAIT, then a late rvalid -> valid_o=0 and fetch restarts at PC_RESET. With FETCH_PERF_CNT_EN defined, both counters read 0.
